// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port and a busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.

module rf_rdport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] rd_o,
    output logic              rv_o,
    output logic              rb_o
);
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;
    logic              rb_q;

    // Data and busy are captured only on a request; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            rv_q <= 1'b0;
            rb_q <= 1'b0;
        end else begin
            rv_q <= re_i;
            if (re_i) begin
                rd_q <= data_i;
                rb_q <= busy_i;
            end
        end
    end

    assign rd_o = rd_q;
    assign rv_o = rv_q;
    assign rb_o = rb_q;
endmodule

module regfile_sb #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    output logic              rv1,
    output logic              rb1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    output logic              rv2,
    output logic              rb2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_a,
    output logic [DEPTH-1:0]  busy_vec
);
    localparam int NPORTS = 2;

    logic [DEPTH-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DEPTH-1:0]              busy_q, busy_d;

    logic [NPORTS-1:0]             re;
    logic [NPORTS-1:0][ADDR_W-1:0] ra;
    logic [NPORTS-1:0][DATA_W-1:0] rdata;
    logic [NPORTS-1:0]             rbusy;
    logic [NPORTS-1:0][DATA_W-1:0] rd;
    logic [NPORTS-1:0]             rv;
    logic [NPORTS-1:0]             rb;

    assign re = {re2, re1};
    assign ra = {ra2, ra1};

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we && wa != '0) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
        end
        // Applied after the clear so a same-edge reserve wins over the write.
        if (rsv_en && rsv_a != '0)
            busy_d[rsv_a] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
`ifdef REGFILE_SB_BYPASS_EN
        logic hit;
        assign hit      = we && (wa != '0) && (wa == ra[p]);
        assign rdata[p] = hit ? wd : regs_q[ra[p]];
`else
        assign rdata[p] = regs_q[ra[p]];
`endif
        // Busy is sampled from pre-edge state regardless of forwarding.
        assign rbusy[p] = busy_q[ra[p]];

        rf_rdport #(.DATA_W(DATA_W)) u_port (
            .clk    (clk),
            .rst_n  (rst_n),
            .re_i   (re[p]),
            .data_i (rdata[p]),
            .busy_i (rbusy[p]),
            .rd_o   (rd[p]),
            .rv_o   (rv[p]),
            .rb_o   (rb[p])
        );
    end

    assign rd1      = rd[0];
    assign rv1      = rv[0];
    assign rb1      = rb[0];
    assign rd2      = rd[1];
    assign rv2      = rv[1];
    assign rb2      = rb[1];
    assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, reads, writes, address 0, forwarding, scoreboard.
// Expected forwarding result follows REGFILE_SB_BYPASS_EN.

module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              re1, re2, we, rsv_en;
    logic [ADDR_W-1:0] ra1, ra2, wa, rsv_a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd1, rd2;
    logic              rv1, rv2, rb1, rb2;
    logic [DEPTH-1:0]  busy_vec;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .re1(re1), .ra1(ra1), .rd1(rd1), .rv1(rv1), .rb1(rb1),
        .re2(re2), .ra2(ra2), .rd2(rd2), .rv2(rv2), .rb2(rb2),
        .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re1 = 0; re2 = 0; we = 0; rsv_en = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DATA_W-1:0] fwd_exp;

    initial begin
`ifdef REGFILE_SB_BYPASS_EN
        fwd_exp = 32'hA5A5A5A5;
`else
        fwd_exp = 32'h1;
`endif
        ra1 = 0; ra2 = 0; wa = 0; rsv_a = 0; wd = 0;
        idle();
        // Reset held while a write of 5 is presented
        rst_n = 0;
        we = 1; wa = 5; wd = 32'hDEADBEEF;
        rsv_en = 1; rsv_a = 5;
        tick(); tick();
        chk("rst_rv1", 64'(rv1), 0);
        chk("rst_rd1", 64'(rd1), 0);
        chk("rst_busy", 64'(busy_vec), 0);
        rst_n = 1;
        idle();
        re1 = 1; ra1 = 5;
        tick();
        chk("post_rst_rd1", 64'(rd1), 0);
        chk("post_rst_rv1", 64'(rv1), 1);
        chk("post_rst_busy", 64'(busy_vec), 0);

        // Write 3, dual-port read
        idle(); we = 1; wa = 3; wd = 32'h12345678;
        tick();
        idle(); re1 = 1; re2 = 1; ra1 = 3; ra2 = 3;
        tick();
        chk("dual_rd1", 64'(rd1), 64'h12345678);
        chk("dual_rd2", 64'(rd2), 64'h12345678);
        chk("dual_rv1", 64'(rv1), 1);
        chk("dual_rv2", 64'(rv2), 1);

        // Address 0 write/reserve ignored
        idle(); we = 1; wa = 0; wd = 32'hFFFFFFFF; rsv_en = 1; rsv_a = 0;
        tick();
        idle(); re1 = 1; ra1 = 0;
        tick();
        chk("zero_rd1", 64'(rd1), 0);
        chk("zero_busy0", 64'(busy_vec[0]), 0);
        chk("zero_busy", 64'(busy_vec), 0);

        // Same-edge write and read of 7
        idle(); we = 1; wa = 7; wd = 32'h1;
        tick();
        idle(); we = 1; wa = 7; wd = 32'hA5A5A5A5; re1 = 1; ra1 = 7;
        re2 = 1; ra2 = 3;
        tick();
        chk("fwd_rd1", 64'(rd1), 64'(fwd_exp));
        chk("indep_rd2", 64'(rd2), 64'h12345678);
        idle(); re1 = 1; ra1 = 7;
        tick();
        chk("after_fwd_rd1", 64'(rd1), 64'hA5A5A5A5);

        // Scoreboard
        idle(); rsv_en = 1; rsv_a = 9;
        tick();
        chk("rsv_busy", 64'(busy_vec), 64'(32'h200));
        idle(); re2 = 1; ra2 = 9;
        tick();
        chk("rsv_rb2", 64'(rb2), 1);
        idle(); rsv_en = 1; rsv_a = 9;
        tick();
        chk("rsv_again", 64'(busy_vec[9]), 1);
        // Write clears; same-edge read still sees pre-edge busy
        idle(); we = 1; wa = 9; wd = 32'h77; re2 = 1; ra2 = 9;
        tick();
        chk("wr_clear", 64'(busy_vec[9]), 0);
        chk("pre_edge_rb2", 64'(rb2), 1);
        idle(); re2 = 1; ra2 = 9;
        tick();
        chk("clear_rb2", 64'(rb2), 0);
        idle(); rsv_en = 1; rsv_a = 9; we = 1; wa = 9; wd = 32'h99;
        tick();
        chk("rsv_wins", 64'(busy_vec), 64'(32'h200));
        idle(); re1 = 1; ra1 = 9;
        tick();
        chk("rsv_wins_data", 64'(rd1), 64'h99);
        chk("rsv_wins_rb1", 64'(rb1), 1);
        idle(); we = 1; wa = 4; wd = 32'h4;
        tick();
        chk("wr_nonbusy", 64'(busy_vec), 64'(32'h200));

        // Hold after valid read
        idle(); we = 1; wa = 11; wd = 32'h55;
        tick();
        idle(); re1 = 1; ra1 = 11;
        tick();
        chk("hold_pre_rd1", 64'(rd1), 64'h55);
        idle(); ra1 = 3;
        tick();
        chk("hold_rv1", 64'(rv1), 0);
        chk("hold_rd1", 64'(rd1), 64'h55);
        tick();
        chk("hold2_rd1", 64'(rd1), 64'h55);

        // Asynchronous reset mid-cycle during activity
        idle(); re1 = 1; ra1 = 11; rsv_en = 1; rsv_a = 12;
        tick();
        chk("pre_arst_rv1", 64'(rv1), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_rv1", 64'(rv1), 0);
        chk("arst_rd1", 64'(rd1), 0);
        chk("arst_busy", 64'(busy_vec), 0);
        idle();
        tick();
        rst_n = 1;
        re1 = 1; ra1 = 3; re2 = 1; ra2 = 11;
        tick();
        chk("arst_reg3", 64'(rd1), 0);
        chk("arst_reg11", 64'(rd2), 0);
        chk("arst_resume_rv", 64'(rv2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W, 32, register data width in bits
  DEPTH, 32, number of registers, power of two, at least 2
  ADDR_W, $clog2(DEPTH), address width, derived, not overridden
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  asynchronous active-low reset
  re1  in  1  read port 1 request
  ra1  in  ADDR_W  read port 1 address
  rd1  out  DATA_W  read port 1 data, registered
  rv1  out  1  read port 1 data valid
  rb1  out  1  read port 1 register busy (scoreboard) at sample time
  re2, ra2, rd2, rv2, rb2  same as port 1, for read port 2
  we  in  1  write enable
  wa  in  ADDR_W  write address
  wd  in  DATA_W  write data
  rsv_en  in  1  reserve request: mark register rsv_a busy
  rsv_a  in  ADDR_W  reserve address
  busy_vec  out  DEPTH  current scoreboard bits, bit i = register i busy

Function
REQ-003 Storage SHALL be DEPTH registers of DATA_W bits; register 0 SHALL always read 0, and writes and reserves to address 0 SHALL be ignored.
REQ-004 Writes SHALL commit on the rising clk edge when we=1 and wa!=0.
REQ-005 Reads SHALL have 1-cycle latency: when reix=1 at edge N, rdx/rbx SHALL hold the sampled values and rvx=1 after edge N.
REQ-006 When reix=0 at an edge, rvx SHALL go 0 and rdx/rbx SHALL hold their previous values.
REQ-007 Each read port SHALL be independent; both ports reading the same address SHALL return identical data.
REQ-008 Scoreboard: rsv_en=1 with rsv_a!=0 SHALL set busy[rsv_a] at the edge; we=1 with wa!=0 SHALL clear busy[wa] at the edge.
REQ-009 rsv_en and we targeting the same nonzero address at the same edge SHALL leave busy set (reserve wins); the data write SHALL still commit.
REQ-010 Reserving an already busy register SHALL leave it busy; writing a non-busy register SHALL leave it clear.
REQ-011 busy_vec[0] SHALL be 0 at all times; busy_vec SHALL be driven directly from state (no added latency).
REQ-012 rbx SHALL reflect the busy bit as seen before the same-edge update (pre-edge state), independent of bypass configuration.

Reset
REQ-013 rst_n=0 SHALL asynchronously clear all registers to 0, busy_vec to 0, rd1/rd2 to 0, rv1/rv2 to 0 and rb1/rb2 to 0.
REQ-014 Reset assertion during any activity SHALL discard in-flight reads (rvx=0) and the same-edge write; operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-015 Macro REGFILE_SB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-016 With REGFILE_SB_BYPASS_EN defined: a read and a write (we=1) to the same nonzero address at the same edge SHALL return the new wd on rdx.
REQ-017 Without REGFILE_SB_BYPASS_EN: that read SHALL return the pre-write stored value; the new value SHALL be visible from the next read.

Verification
REQ-018 Reset: hold rst_n=0 mid-write of wa=5, wd=0xDEADBEEF; release; read ra1=5 -> rd1=0, rv1=1, busy_vec=0.
REQ-019 Write wa=3, wd=0x12345678; next cycle re1=re2=1, ra1=ra2=3 -> rd1=rd2=0x12345678, rv1=rv2=1 one cycle later.
REQ-020 Write wa=0, wd=0xFFFFFFFF, rsv_a=0, rsv_en=1; read ra1=0 -> rd1=0, busy_vec[0]=0.
REQ-021 Same edge: we=1, wa=7, wd=0xA5A5A5A5, re1=1, ra1=7, old value 0x1 -> rd1=0xA5A5A5A5 with bypass, 0x1 without.
REQ-022 rsv_en=1, rsv_a=9 -> busy_vec[9]=1; read ra2=9 -> rb2=1; write wa=9 -> busy_vec[9]=0; simultaneous rsv_a=9 and wa=9 -> busy_vec[9]=1.
REQ-023 Hold re1=0 after a valid read of 0x55 -> rv1=0, rd1 stays 0x55.
